muldiv_unit: RTL
================

// Module: muldiv_unit
//
// PURPOSE
//   Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
//   Operands come from regfile read ports rd1/rd2.
//   HI/LO feed the write-back mux for MFHI/MFLO.
//   Controller stalls issue while busy=1.
//   Implements MULT, MULTU, DIV, DIVU (radix-2, one bit per cycle), MTHI and MTLO.
//
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
//
// PORTS
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous, active-high
//   start  in   1      op request; sampled only when busy=0
//   op     in   3      muldiv_pkg::md_op_t
//   a      in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//   b      in   WIDTH  rt operand (divisor / multiplier)
//   busy   out  1      high while a MULT/DIV is in progress
//   done   out  1      one-cycle pulse: HI/LO updated by a MULT/DIV
//   hi     out  WIDTH  HI register (product upper half / remainder)
//   lo     out  WIDTH  LO register (product lower half / quotient)
//
// BEHAVIOUR
//   Reset
//     - reset=1 forces state=IDLE, busy=0, done=0, hi=0, lo=0 immediately.
//     - Reset mid-operation aborts the operation; no partial result is kept.
//   States
//     - IDLE -> RUN on start & MULT/DIV op.
//     - RUN: WIDTH edges, one iteration per edge, then -> FIX.
//     - FIX -> IDLE on the next edge; hi/lo written, done=1 for the following cycle.
//   Latency
//     - start sampled at edge E0.
//     - busy=1 from E0 through E(WIDTH+1).
//     - hi/lo and done=1 valid after E(WIDTH+1): 33 cycles for WIDTH=32.
//   Handshake
//     - start while busy=1 is ignored.
//     - start in the cycle where done=1 is accepted (state is IDLE).
//   MTHI/MTLO
//     - start & op=MTHI|MTLO with busy=0: hi (or lo) <= a at the next edge.
//     - No busy, no done.
//   Reserved op codes (6,7): ignored, no state change.
//   Signed handling (MULT, DIV)
//     - Operands are converted to magnitude at E0; the core iterates unsigned.
//     - FIX applies the signs:
//       - product negated if sign(a)^sign(b);
//       - quotient negated if sign(a)^sign(b);
//       - remainder takes the sign of a.
//     - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
//   Multiply
//     - Shift-add over a 2*WIDTH accumulator.
//     - {hi,lo} = full 2*WIDTH-bit product.
//   Divide
//     - Restoring: lo = quotient, hi = remainder.
//     - Divide by zero (b=0): lo = all ones, hi = a (signed or unsigned form); full latency.
//   Operands a/b may change after E0; they are captured internally.
//
// STRUCTURE
//   muldiv_pkg holds:
//     - md_op_t enum {MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5}
//     - md_state_t enum {IDLE, RUN, FIX}
//   Sub-module cond_negate #(WIDTH): y = neg ? -x : x.
//     - Used for operand magnitude and result sign fix.
//   Iteration counter: $clog2(WIDTH)+1 bits.
//   hi/lo are plain registers with no write-enable sub-module.
//
// TESTING
//   1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle.
//   2. MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   3. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. start MULT, then start DIV during busy -> second request ignored; result is the MULT product only.
//   5. MTLO a=0x1234 while idle -> lo=0x1234 next cycle, busy/done stay 0; back-to-back start on done cycle accepted.
//   6. reset asserted mid-RUN (cycle 10) -> busy=0, hi=lo=0 immediately; no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared types and small decode helpers for the iterative multiply/divide
//   unit.
//   md_op_t    : operation code presented on muldiv_unit.op (codes 6 and 7
//                are reserved and decode as "no operation").
//   md_state_t : control FSM state encoding.
// ---------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   // Operations that occupy the iterative core (multiply and divide)
   function automatic logic is_long_op(input logic [2:0] code);
      return (code == MD_MULT) || (code == MD_MULTU) ||
             (code == MD_DIV)  || (code == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] code);
      return (code == MD_MULT) || (code == MD_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] code);
      return (code == MD_DIV) || (code == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate
//   Conditional two's-complement negation: y = neg ? -x : x.
//   Used both to take operand magnitudes and to apply result signs.
//   Ports:
//     neg  in   1      negate when high
//     x    in   WIDTH  value
//     y    out  WIDTH  result
// ---------------------------------------------------------------------------
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (-x) : x;

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider, one
//   bit per clock.  Signed operations iterate on magnitudes and the signs are
//   applied in the FIX state.  MTHI/MTLO write HI/LO directly in one cycle.
//   Ports:
//     clk    in   1      clock, rising edge
//     reset  in   1      asynchronous, active-high
//     start  in   1      operation request, sampled only while idle
//     op     in   3      operation code (muldiv_pkg::md_op_t)
//     a      in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//     b      in   WIDTH  rt operand (multiplier / divisor)
//     busy   out  1      high while a multiply or divide is in progress
//     done   out  1      one-cycle pulse after HI/LO receive a MULT/DIV result
//     hi     out  WIDTH  HI register (product upper half / remainder)
//     lo     out  WIDTH  LO register (product lower half / quotient)
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   md_state_t            state_reg, state_next;
   logic [CNT_W-1:0]     count_reg;
   logic [2*WIDTH-1:0]   acc_reg;       // {remainder, quotient} or {product}
   logic [WIDTH-1:0]     operand_reg;   // multiplicand or divisor magnitude
   logic                 is_div_reg;
   logic                 neg_result_reg;
   logic                 neg_rem_reg;
   logic                 done_reg;
   logic [WIDTH-1:0]     hi_reg, lo_reg;

   logic load, step, finish, write_hi, write_lo;

   // ---------------- operand decode and magnitude ----------------
   logic             op_signed, op_div, sign_a, sign_b, neg_result_in;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign op_signed = is_signed_op(op);
   assign op_div    = is_div_op(op);
   assign sign_a    = op_signed & a[WIDTH-1];
   assign sign_b    = op_signed & b[WIDTH-1];
   // A zero divisor must leave the quotient as all ones, so its sign fix is
   // suppressed; the remainder sign fix then simply restores a.
   assign neg_result_in = (sign_a ^ sign_b) & ~(op_div & (b == '0));

   cond_negate #(.WIDTH(WIDTH)) u_mag_a (.neg(sign_a), .x(a), .y(mag_a));
   cond_negate #(.WIDTH(WIDTH)) u_mag_b (.neg(sign_b), .x(b), .y(mag_b));

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (is_long_op(op)) begin
                  load       = 1'b1;
                  state_next = RUN;
               end else if (op == MD_MTHI) begin
                  write_hi = 1'b1;
               end else if (op == MD_MTLO) begin
                  write_lo = 1'b1;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (count_reg == CNT_W'(1)) state_next = FIX;
         end
         FIX: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- iteration datapath ----------------
   // Multiply: add multiplicand into the upper half when the current
   // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   // Divide: shift remainder:dividend left, trial-subtract the divisor from
   // the (WIDTH+1)-bit partial remainder; a borrow means restore.
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, operand_reg};
   assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                                : {1'b0, acc_reg[2*WIDTH-1:1]};

   assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, operand_reg};
   assign div_next  = div_diff[WIDTH]
                    ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

   // ---------------- sign fix ----------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
      .neg(neg_result_reg), .x(acc_reg), .y(prod_fix));
   cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
      .neg(neg_result_reg), .x(acc_reg[WIDTH-1:0]), .y(quot_fix));
   cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .neg(neg_rem_reg), .x(acc_reg[2*WIDTH-1:WIDTH]), .y(rem_fix));

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg      <= '0;
         acc_reg        <= '0;
         operand_reg    <= '0;
         is_div_reg     <= 1'b0;
         neg_result_reg <= 1'b0;
         neg_rem_reg    <= 1'b0;
         done_reg       <= 1'b0;
         hi_reg         <= '0;
         lo_reg         <= '0;
      end else begin
         done_reg <= finish;

         if (load) begin
            count_reg      <= CNT_W'(WIDTH);
            is_div_reg     <= op_div;
            neg_result_reg <= neg_result_in;
            neg_rem_reg    <= sign_a;
            if (op_div) begin
               acc_reg     <= {{WIDTH{1'b0}}, mag_a};
               operand_reg <= mag_b;
            end else begin
               acc_reg     <= {{WIDTH{1'b0}}, mag_b};
               operand_reg <= mag_a;
            end
         end else if (step) begin
            count_reg <= count_reg - CNT_W'(1);
            acc_reg   <= is_div_reg ? div_next : mul_next;
         end

         if (finish) begin
            if (is_div_reg) begin
               hi_reg <= rem_fix;
               lo_reg <= quot_fix;
            end else begin
               hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
               lo_reg <= prod_fix[WIDTH-1:0];
            end
         end else begin
            if (write_hi) hi_reg <= a;
            if (write_lo) lo_reg <= a;
         end
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule
